// File: rtl/rip_axi_arbiter_pkg.sv
// Shared constants and types for the rip AXI requester arbiter.
// Holds the per-channel FSM state encoding and the byte width used for strobes.
package rip_const;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_BUSY} arb_state_e;

    localparam int B_WIDTH = 8;

endpackage

// File: rtl/rip_axi_arbiter_rr.sv
// Round-robin picker: first unmasked valid index scanning upward from last_grant+1.
// Purely combinational; one instance per AXI channel.
module rip_rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index,
    output logic          any
);

    always_comb begin : scan
        int cand;
        grant = '0;
        index = '0;
        any   = 1'b0;
        cand  = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last_grant) + k) % N;
            if (!any && valid[cand] && !mask[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                index       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/rip_axi_arbiter.sv
// Shares one AXI master's simple write/read ports among N_REQ requesters, one transaction per channel.
// Optional build macro: RIP_AXI_ARB_RAW_GUARD_EN holds reads that hit the line of an in-flight write.
module rip_axi_arbiter
    import rip_const::*;
#(
    parameter  int N_REQ      = 2,
    parameter  int ADDR_WIDTH = 32,
    parameter  int LINE_WIDTH = 32*8,
    parameter  int STRB_WIDTH = LINE_WIDTH/B_WIDTH,
    localparam int IW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [N_REQ-1:0]            req_wvalid,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_waddr,
    input  logic [N_REQ*LINE_WIDTH-1:0] req_wdata,
    input  logic [N_REQ*STRB_WIDTH-1:0] req_wstrb,
    output logic [N_REQ-1:0]            req_wready,
    output logic [N_REQ-1:0]            req_wdone,
    input  logic [N_REQ-1:0]            req_rvalid,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_raddr,
    output logic [N_REQ-1:0]            req_rready,
    output logic [LINE_WIDTH-1:0]       req_rdata,
    output logic [N_REQ-1:0]            req_rdone,
    input  logic                        m_wready,
    output logic [ADDR_WIDTH-1:0]       m_waddr,
    output logic [LINE_WIDTH-1:0]       m_wdata,
    output logic [STRB_WIDTH-1:0]       m_wstrb,
    output logic                        m_wvalid,
    input  logic                        m_wdone,
    input  logic                        m_rready,
    output logic [ADDR_WIDTH-1:0]       m_raddr,
    output logic                        m_rvalid,
    input  logic [LINE_WIDTH-1:0]       m_rdata,
    input  logic                        m_rdone
);

    localparam int LINE_SHIFT = $clog2(LINE_WIDTH/8);

    arb_state_e            w_state_q, w_state_d, r_state_q, r_state_d;
    logic [IW-1:0]         w_idx_q, w_idx_d, r_idx_q, r_idx_d;
    logic [IW-1:0]         w_last_q, w_last_d, r_last_q, r_last_d;
    logic [ADDR_WIDTH-1:0] m_waddr_q, m_waddr_d, m_raddr_q, m_raddr_d;
    logic [LINE_WIDTH-1:0] m_wdata_q, m_wdata_d;
    logic [STRB_WIDTH-1:0] m_wstrb_q, m_wstrb_d;
    logic                  m_wvalid_q, m_wvalid_d, m_rvalid_q, m_rvalid_d;

    logic [N_REQ-1:0] w_grant, r_grant, r_mask;
    logic [IW-1:0]    w_index, r_index;
    logic             w_any, r_any;

    rip_rr_arbiter #(.N(N_REQ)) u_w_arb (
        .valid(req_wvalid), .mask('0), .last_grant(w_last_q),
        .grant(w_grant), .index(w_index), .any(w_any)
    );

    rip_rr_arbiter #(.N(N_REQ)) u_r_arb (
        .valid(req_rvalid), .mask(r_mask), .last_grant(r_last_q),
        .grant(r_grant), .index(r_index), .any(r_any)
    );

`ifdef RIP_AXI_ARB_RAW_GUARD_EN
    // m_waddr_q holds the in-flight write address for all of ISSUE and BUSY.
    always_comb begin
        r_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            r_mask[i] = (w_state_q != ARB_IDLE) &&
                        ((req_raddr[i*ADDR_WIDTH +: ADDR_WIDTH] >> LINE_SHIFT) ==
                         (m_waddr_q >> LINE_SHIFT));
        end
    end
`else
    assign r_mask = '0;
`endif

    // NOTE: combinational blocks use blocking '=' with every output defaulted first, so no latches form.
    always_comb begin
        w_state_d  = w_state_q;
        w_idx_d    = w_idx_q;
        w_last_d   = w_last_q;
        m_waddr_d  = m_waddr_q;
        m_wdata_d  = m_wdata_q;
        m_wstrb_d  = m_wstrb_q;
        m_wvalid_d = m_wvalid_q;
        req_wready = '0;
        req_wdone  = '0;
        case (w_state_q)
            ARB_IDLE: begin
                if (w_any) begin
                    req_wready = w_grant;
                    w_idx_d    = w_index;
                    m_waddr_d  = req_waddr[w_index*ADDR_WIDTH +: ADDR_WIDTH];
                    m_wdata_d  = req_wdata[w_index*LINE_WIDTH +: LINE_WIDTH];
                    m_wstrb_d  = req_wstrb[w_index*STRB_WIDTH +: STRB_WIDTH];
                    m_wvalid_d = 1'b1;
                    w_state_d  = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (m_wvalid_q && m_wready) begin
                    m_wvalid_d = 1'b0;
                    w_state_d  = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (m_wdone) begin
                    req_wdone[w_idx_q] = 1'b1;
                    w_last_d           = w_idx_q;
                    w_state_d          = ARB_IDLE;
                end
            end
            default: w_state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        r_state_d  = r_state_q;
        r_idx_d    = r_idx_q;
        r_last_d   = r_last_q;
        m_raddr_d  = m_raddr_q;
        m_rvalid_d = m_rvalid_q;
        req_rready = '0;
        req_rdone  = '0;
        case (r_state_q)
            ARB_IDLE: begin
                if (r_any) begin
                    req_rready = r_grant;
                    r_idx_d    = r_index;
                    m_raddr_d  = req_raddr[r_index*ADDR_WIDTH +: ADDR_WIDTH];
                    m_rvalid_d = 1'b1;
                    r_state_d  = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (m_rvalid_q && m_rready) begin
                    m_rvalid_d = 1'b0;
                    r_state_d  = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (m_rdone) begin
                    req_rdone[r_idx_q] = 1'b1;
                    r_last_d           = r_idx_q;
                    r_state_d          = ARB_IDLE;
                end
            end
            default: r_state_d = ARB_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking '<='; payload registers are reset too because they drive ports.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            w_state_q  <= ARB_IDLE;
            r_state_q  <= ARB_IDLE;
            w_idx_q    <= '0;
            r_idx_q    <= '0;
            w_last_q   <= IW'(N_REQ-1);
            r_last_q   <= IW'(N_REQ-1);
            m_waddr_q  <= '0;
            m_wdata_q  <= '0;
            m_wstrb_q  <= '0;
            m_wvalid_q <= 1'b0;
            m_raddr_q  <= '0;
            m_rvalid_q <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            w_idx_q    <= w_idx_d;
            r_idx_q    <= r_idx_d;
            w_last_q   <= w_last_d;
            r_last_q   <= r_last_d;
            m_waddr_q  <= m_waddr_d;
            m_wdata_q  <= m_wdata_d;
            m_wstrb_q  <= m_wstrb_d;
            m_wvalid_q <= m_wvalid_d;
            m_raddr_q  <= m_raddr_d;
            m_rvalid_q <= m_rvalid_d;
        end
    end

    assign m_waddr   = m_waddr_q;
    assign m_wdata   = m_wdata_q;
    assign m_wstrb   = m_wstrb_q;
    assign m_wvalid  = m_wvalid_q;
    assign m_raddr   = m_raddr_q;
    assign m_rvalid  = m_rvalid_q;
    assign req_rdata = m_rdata;

endmodule

// File: tb/tb_rip_axi_arbiter.sv
// Directed self-checking bench for rip_axi_arbiter (2 requesters, 256-bit lines).
// Expectations follow RIP_AXI_ARB_RAW_GUARD_EN if the bench is built with it defined.
module tb_rip_axi_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int LW = 256;
    localparam int SW = LW/8;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    req_wvalid, req_wready, req_wdone;
    logic [N*AW-1:0] req_waddr, req_raddr;
    logic [N*LW-1:0] req_wdata;
    logic [N*SW-1:0] req_wstrb;
    logic [N-1:0]    req_rvalid, req_rready, req_rdone;
    logic [LW-1:0]   req_rdata, m_rdata, m_wdata;
    logic            m_wready, m_wvalid, m_wdone, m_rready, m_rvalid, m_rdone;
    logic [AW-1:0]   m_waddr, m_raddr;
    logic [SW-1:0]   m_wstrb;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rip_axi_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rstn(rstn),
        .req_wvalid(req_wvalid), .req_waddr(req_waddr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .req_wready(req_wready), .req_wdone(req_wdone),
        .req_rvalid(req_rvalid), .req_raddr(req_raddr), .req_rready(req_rready),
        .req_rdata(req_rdata), .req_rdone(req_rdone),
        .m_wready(m_wready), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wvalid(m_wvalid), .m_wdone(m_wdone),
        .m_rready(m_rready), .m_raddr(m_raddr), .m_rvalid(m_rvalid),
        .m_rdata(m_rdata), .m_rdone(m_rdone)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one read with both requesters asserting continuously; exp_idx is the expected winner.
    task automatic do_read(input int exp_idx, input logic [255:0] val);
        logic [255:0] oh;
        logic [255:0] addr;
        oh   = 256'(1) << exp_idx;
        addr = (exp_idx == 0) ? 256'h1000 : 256'h2000;
        #1 check("rr_ready", 256'(req_rready), oh);
        @(posedge clk);
        @(negedge clk);
        #1 check("rr_mvalid", 256'(m_rvalid), 256'd1);
        check("rr_maddr", 256'(m_raddr), addr);
        check("rr_ready_issue", 256'(req_rready), 256'd0);
        @(posedge clk);
        @(negedge clk);
        m_rdata = val;
        m_rdone = 1'b1;
        #1 check("rr_done", 256'(req_rdone), oh);
        check("rr_data", req_rdata, val);
        @(posedge clk);
        @(negedge clk);
        m_rdone = 1'b0;
    endtask

    initial begin
        rstn       = 1'b0;
        req_wvalid = '0;
        req_waddr  = '0;
        req_wdata  = '0;
        req_wstrb  = '0;
        req_rvalid = '0;
        req_raddr  = '0;
        m_wready   = 1'b1;
        m_rready   = 1'b1;
        m_wdone    = 1'b0;
        m_rdone    = 1'b0;
        m_rdata    = '0;

        // Reset with no requests
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1 check("rst_ready", 256'({req_wready, req_rready}), 256'd0);
        check("rst_done", 256'({req_wdone, req_rdone}), 256'd0);
        check("rst_mvalid", 256'({m_wvalid, m_rvalid}), 256'd0);
        check("rst_maddr", 256'({m_waddr, m_raddr}), 256'd0);

        // Single write from requester 0
        req_wvalid        = 2'b01;
        req_waddr[0 +: AW] = 32'h100;
        req_wdata[0 +: LW] = 256'hA5;
        req_wstrb[0 +: SW] = 32'hF;
        #1 check("w_ready", 256'(req_wready), 256'b01);
        @(posedge clk);
        @(negedge clk);
        req_wvalid = '0;
        #1 check("w_mvalid", 256'(m_wvalid), 256'd1);
        check("w_maddr", 256'(m_waddr), 256'h100);
        check("w_mdata", m_wdata, 256'hA5);
        check("w_mstrb", 256'(m_wstrb), 256'hF);
        check("w_ready_issue", 256'(req_wready), 256'd0);
        @(posedge clk);
        @(negedge clk);
        #1 check("w_mvalid_busy", 256'(m_wvalid), 256'd0);
        check("w_maddr_hold", 256'(m_waddr), 256'h100);
        m_wdone = 1'b1;
        #1 check("w_done", 256'(req_wdone), 256'b01);
        @(posedge clk);
        @(negedge clk);
        #1 check("w_done_idle_ignored", 256'(req_wdone), 256'd0);
        m_wdone = 1'b0;

        // Round-robin fairness on reads
        req_rvalid          = 2'b11;
        req_raddr[0 +: AW]  = 32'h1000;
        req_raddr[AW +: AW] = 32'h2000;
        do_read(0, 256'h1111);
        do_read(1, 256'h2222);
        do_read(0, 256'h3333);
        do_read(1, 256'h4444);
        req_rvalid = '0;

        // Concurrent write (req0) and read (req1)
        req_wvalid          = 2'b01;
        req_waddr[0 +: AW]  = 32'h300;
        req_rvalid          = 2'b10;
        req_raddr[AW +: AW] = 32'h400;
        #1 check("wr_ready", 256'({req_wready, req_rready}), 256'b0110);
        @(posedge clk);
        @(negedge clk);
        req_wvalid = '0;
        req_rvalid = '0;
        #1 check("wr_mvalid", 256'({m_wvalid, m_rvalid}), 256'b11);
        @(posedge clk);
        @(negedge clk);
        #1 check("wr_busy_mvalid", 256'({m_wvalid, m_rvalid}), 256'b00);
        m_wdone = 1'b1;
        m_rdone = 1'b1;
        m_rdata = 256'hBEEF;
        #1 check("wr_done", 256'({req_wdone, req_rdone}), 256'b0110);
        check("wr_rdata", req_rdata, 256'hBEEF);
        @(posedge clk);
        @(negedge clk);
        m_wdone = 1'b0;
        m_rdone = 1'b0;

        // Read-after-write on the same line
        req_wvalid         = 2'b01;
        req_waddr[0 +: AW] = 32'h200;
        #1 check("raw_wready", 256'(req_wready), 256'b01);
        @(posedge clk);
        @(negedge clk);
        req_wvalid          = '0;
        req_rvalid          = 2'b10;
        req_raddr[AW +: AW] = 32'h204;
`ifdef RIP_AXI_ARB_RAW_GUARD_EN
        #1 check("raw_blocked_issue", 256'(req_rready), 256'd0);
        @(posedge clk);
        @(negedge clk);
        #1 check("raw_blocked_busy", 256'(req_rready), 256'd0);
        m_wdone = 1'b1;
        #1 check("raw_wdone", 256'(req_wdone), 256'b01);
        check("raw_blocked_done", 256'(req_rready), 256'd0);
        @(posedge clk);
        @(negedge clk);
        m_wdone = 1'b0;
        #1 check("raw_released", 256'(req_rready), 256'b10);
        @(posedge clk);
        @(negedge clk);
        req_rvalid = '0;
        @(posedge clk);
        @(negedge clk);
        m_rdone = 1'b1;
        #1 check("raw_rdone", 256'(req_rdone), 256'b10);
        @(posedge clk);
        @(negedge clk);
        m_rdone = 1'b0;
`else
        #1 check("raw_unguarded", 256'(req_rready), 256'b10);
        @(posedge clk);
        @(negedge clk);
        req_rvalid = '0;
        #1 check("raw_maddr", 256'(m_raddr), 256'h204);
        @(posedge clk);
        @(negedge clk);
        m_wdone = 1'b1;
        m_rdone = 1'b1;
        #1 check("raw_dones", 256'({req_wdone, req_rdone}), 256'b0110);
        @(posedge clk);
        @(negedge clk);
        m_wdone = 1'b0;
        m_rdone = 1'b0;
`endif

        // Reset while a write from requester 1 is in BUSY
        req_wvalid          = 2'b10;
        req_waddr[AW +: AW] = 32'h500;
        #1 check("mid_wready", 256'(req_wready), 256'b10);
        @(posedge clk);
        @(negedge clk);
        req_wvalid = '0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn    = 1'b1;
        m_wdone = 1'b1;
        #1 check("mid_no_done", 256'(req_wdone), 256'd0);
        check("mid_mvalid", 256'(m_wvalid), 256'd0);
        check("mid_maddr", 256'(m_waddr), 256'd0);
        m_wdone    = 1'b0;
        req_wvalid = 2'b11;
        #1 check("mid_regrant0", 256'(req_wready), 256'b01);
        @(negedge clk);
        req_wvalid = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rip_axi_arbiter.md
# rip_axi_arbiter

Shares one AXI4 master's simple access ports (write: ready/addr/data/strb/valid/done; read: ready/addr/valid/data/done) among N_REQ requesters, e.g. I-cache, D-cache and DMA. The write and read channels are arbitrated independently with round-robin fairness, and each channel has one transaction in flight. The block sits between the cache refill/writeback logic and the AXI master, and adds no AXI-side logic.

## Interface
Parameters:
- N_REQ, 2, number of requesters (≥2)
- ADDR_WIDTH, 32, address width
- LINE_WIDTH, 32*8, bits per transaction (DATA_WIDTH*BURST_LEN of the master)
- STRB_WIDTH, LINE_WIDTH/B_WIDTH, byte strobes per transaction

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- req_wvalid  in  N_REQ  per-requester write request
- req_waddr  in  N_REQ*ADDR_WIDTH  flattened, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  N_REQ*LINE_WIDTH  flattened write data
- req_wstrb  in  N_REQ*STRB_WIDTH  flattened strobes
- req_wready  out  N_REQ  one-hot grant/accept for writes
- req_wdone  out  N_REQ  one-cycle write-completion pulse
- req_rvalid  in  N_REQ  per-requester read request
- req_raddr  in  N_REQ*ADDR_WIDTH  flattened read address
- req_rready  out  N_REQ  one-hot grant/accept for reads
- req_rdata  out  LINE_WIDTH  shared read data, valid while req_rdone is high
- req_rdone  out  N_REQ  one-cycle read-completion pulse
- m_wready  in  1  master ready for a write
- m_waddr / m_wdata / m_wstrb  out  ADDR_WIDTH / LINE_WIDTH / STRB_WIDTH  registered write request
- m_wvalid  out  1  write request valid
- m_wdone  in  1  master write-done pulse
- m_rready  in  1  master ready for a read
- m_raddr  out  ADDR_WIDTH  registered read address
- m_rvalid  out  1  read request valid
- m_rdata  in  LINE_WIDTH  master read data
- m_rdone  in  1  master read-done pulse

## Operation
- Each channel (W and R) runs its own FSM. States: IDLE, ISSUE, BUSY.
- IDLE:
  - The round-robin pick g is the first i with valid[i], scanning from last_grant+1 modulo N_REQ.
  - req_*ready is combinational: one-hot at g in IDLE when any valid is high; otherwise 0.
  - Acceptance is valid[g] && ready[g]. On acceptance: latch g, register the address (and data/strb) into m_*, set m_*valid=1, go to ISSUE.
- ISSUE: on m_*valid && m_*ready, clear m_*valid and go to BUSY. m_* address and data stay stable until the next acceptance.
- BUSY:
  - On m_*done, pulse req_*done[g] for one cycle, set last_grant=g, go to IDLE.
  - req_rdata = m_rdata, combinational broadcast; it is defined only in the req_rdone cycle.
- Requesters hold valid and payload until they see ready; ready is never high for a non-requesting index.
- The W and R channels are fully independent. Both may be in BUSY at once.
- A done pulse arriving outside BUSY is ignored.

## Timing
- Reset values: all outputs 0; both FSMs in IDLE; last_grant = N_REQ-1, so requester 0 wins the first arbitration.
- Acceptance in cycle T puts m_*valid=1 at T+1.
- Master done at cycle D puts req_*done at D, combinational from m_*done && BUSY.
- Back-to-back: the FSM re-arbitrates in the cycle after done. The minimum gap between two grants on one channel is ISSUE + BUSY + 1.
- Reset mid-transaction drops the in-flight request with no done pulse. The master shares rstn.

## Configuration
- RIP_AXI_ARB_RAW_GUARD_EN defined:
  - A read candidate whose line address (addr >> $clog2(LINE_WIDTH/8)) equals the line address of a write in ISSUE or BUSY is masked from read arbitration until that write's done.
  - Other read requesters proceed normally.
- RIP_AXI_ARB_RAW_GUARD_EN undefined: no address comparison. Reads and writes are unordered.

## Structure
- Add typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_BUSY} arb_state_e to rip_const.
- Sub-module rip_rr_arbiter (parameter N; inputs valid, mask, last_grant; output one-hot grant and index), instantiated once per channel.

## Test plan
- Reset: hold rstn=0 for 3 cycles, then release with no requests -> all outputs 0; the FSMs stay in IDLE.
- Single write: req0 writes addr 0x100, data 0xA5, strb 0xF -> m_wvalid at T+1 with m_waddr 0x100; m_wdone pulse -> req_wdone=2'b01 in the same cycle.
- Fairness: req0 and req1 both request reads continuously -> grant sequence 0,1,0,1; each requester receives only its own rdone, with req_rdata equal to m_rdata.
- Simultaneous W and R: req0 writes while req1 reads -> both channels reach BUSY concurrently, and both done pulses reach the correct requester.
- RAW guard (macro on): req0 writes 0x200 while BUSY, req1 reads 0x204 -> req_rready stays 0 until req_wdone, then the read is granted. With the macro off -> the read is granted immediately.
- Reset mid-op: assert rstn=0 during W BUSY -> no req_wdone; m_wvalid=0; the next request is granted to requester 0.
